// File: rtl/line_buf_scanout.sv
// line_buf_scanout
//   Reader end of the ping-pong scanline buffers. When line_start arrives it
//   streams one completed line out of bank A or B as a valid/ready pixel
//   stream. After the last pixel is accepted it releases the bank to the
//   tile renderer with a bank_done pulse.
//
//   Optional feature macro: LINE_CLEAR_ON_READ_EN. When it is defined, the
//   bank is zero-filled (one address per cycle) after the drain and before
//   bank_done is raised.
//
// Ports
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   line_start, line_bank     scanout request pulse and bank select (0=A, 1=B)
//   busy, bank_done, overrun  status: line active, bank released, request dropped
//   pix_valid/ready           pixel stream handshake
//   pix_rgb/attr/last         pixel payload {r,g,b}, d channel, end of line
//   {a,b}_cen/gwen/addr/wen/d bank RAM controls (active-low enables), {d,b,g,r} lanes
//   {a,b}_q                   bank read data, valid the cycle after a read
module line_buf_scanout #(
  parameter int LINE_LEN   = 256,
  parameter int RAM_A_BITS = 8,
  parameter int RAM_D_BITS = 8
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    line_start,
  input  logic                    line_bank,
  output logic                    busy,
  output logic                    bank_done,
  output logic                    overrun,
  output logic                    pix_valid,
  input  logic                    pix_ready,
  output logic [3*RAM_D_BITS-1:0] pix_rgb,
  output logic [RAM_D_BITS-1:0]   pix_attr,
  output logic                    pix_last,
  output logic                    a_cen,
  output logic                    a_gwen,
  output logic [RAM_A_BITS-1:0]   a_addr,
  output logic [4*RAM_D_BITS-1:0] a_wen,
  output logic [4*RAM_D_BITS-1:0] a_d,
  input  logic [4*RAM_D_BITS-1:0] a_q,
  output logic                    b_cen,
  output logic                    b_gwen,
  output logic [RAM_A_BITS-1:0]   b_addr,
  output logic [4*RAM_D_BITS-1:0] b_wen,
  output logic [4*RAM_D_BITS-1:0] b_d,
  input  logic [4*RAM_D_BITS-1:0] b_q
);
  localparam int DW = 4*RAM_D_BITS;
  localparam logic [RAM_A_BITS-1:0] LAST_ADDR = RAM_A_BITS'(LINE_LEN-1);

`ifdef LINE_CLEAR_ON_READ_EN
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2, CLEAR = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2} state_t;
`endif

  // The field order matches the RAM lane order {d,b,g,r}, so a q word
  // can be written into an entry without reshuffling.
  typedef struct packed {
    logic                  last;
    logic [RAM_D_BITS-1:0] d;
    logic [RAM_D_BITS-1:0] b;
    logic [RAM_D_BITS-1:0] g;
    logic [RAM_D_BITS-1:0] r;
  } pix_t;

  state_t                state, state_nxt;
  logic                  bank_q;
  logic [RAM_A_BITS-1:0] rd_addr;
  logic                  inflight, inflight_last;
  pix_t                  fifo [2];
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            cnt;
  pix_t                  head;
  logic                  run, pop, accept, room, issue, last_issue, clearing, sel_bank;
  logic [RAM_A_BITS-1:0] issue_addr, ram_addr;
  logic [2:0]            occ;
`ifdef LINE_CLEAR_ON_READ_EN
  logic [RAM_A_BITS-1:0] clr_addr;
`endif

  assign run       = ~wb_rst_i;
  assign head      = fifo[rd_ptr];
  assign pix_valid = (cnt != 2'd0);
  assign pix_last  = pix_valid & head.last;
  assign pix_rgb   = {head.r, head.g, head.b};
  assign pix_attr  = head.d;
  assign pop       = pix_valid & pix_ready;

  // A request is refused in the cycle bank_done is high. That way the
  // renderer always gets at least one cycle of ownership of the bank.
  assign accept = run & (state == IDLE) & line_start & ~bank_done;

  // Address 0 is issued in the accept cycle itself, so the first pixel
  // appears two cycles after line_start. The occupancy check counts this
  // cycle's pop. This keeps a read in flight while the head drains, which
  // sustains 1 pixel/cycle and still never overfills the two FIFO slots.
  assign occ        = {1'b0, cnt} + {2'b0, inflight} - {2'b0, pop};
  assign room       = (occ < 3'd2);
  assign issue      = accept | (run & (state == READ) & room);
  assign issue_addr = (state == IDLE) ? '0 : rd_addr;
  assign last_issue = issue & (issue_addr == LAST_ADDR);
  assign sel_bank   = (state == IDLE) ? line_bank : bank_q;

`ifdef LINE_CLEAR_ON_READ_EN
  assign clearing = run & (state == CLEAR);
`else
  assign clearing = 1'b0;
`endif

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = last_issue ? DRAIN : READ;
      READ:  if (last_issue) state_nxt = DRAIN;
`ifdef LINE_CLEAR_ON_READ_EN
      DRAIN: if (pop & pix_last) state_nxt = CLEAR;
      CLEAR: if (clr_addr == LAST_ADDR) state_nxt = IDLE;
`else
      DRAIN: if (pop & pix_last) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: the bank that is not selected stays fully deasserted.
  always_comb begin
    busy = (state != IDLE);
`ifdef LINE_CLEAR_ON_READ_EN
    ram_addr = clearing ? clr_addr : (issue ? issue_addr : '0);
`else
    ram_addr = issue ? issue_addr : '0;
`endif
    a_cen  = ~((issue | clearing) & ~sel_bank);
    b_cen  = ~((issue | clearing) &  sel_bank);
    a_gwen = ~(clearing & ~sel_bank);
    b_gwen = ~(clearing &  sel_bank);
    a_wen  = {DW{a_gwen}};
    b_wen  = {DW{b_gwen}};
    a_addr = ~sel_bank ? ram_addr : '0;
    b_addr =  sel_bank ? ram_addr : '0;
    a_d    = '0;
    b_d    = '0;
  end

  // Read pipeline, output FIFO and status pulses
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      bank_q        <= 1'b0;
      rd_addr       <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      fifo[0]       <= '0;
      fifo[1]       <= '0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      cnt           <= 2'd0;
      bank_done     <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (accept) bank_q <= line_bank;
      if (issue)  rd_addr <= issue_addr + 1'b1;
      inflight      <= issue;
      inflight_last <= last_issue;
      if (inflight) begin
        fifo[wr_ptr] <= {inflight_last, (bank_q ? b_q : a_q)};
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt       <= cnt + {1'b0, inflight} - {1'b0, pop};
      bank_done <= (state != IDLE) & (state_nxt == IDLE);
      overrun   <= line_start & ((state != IDLE) | bank_done);
    end
  end

`ifdef LINE_CLEAR_ON_READ_EN
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)              clr_addr <= '0;
    else if (state == CLEAR)   clr_addr <= clr_addr + 1'b1;
    else                       clr_addr <= '0;
  end
`endif

endmodule
